// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared channel state type and default parameters for timer_multi
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int NUM_CH_DEF  = 4;
  localparam int WIDTH_DEF   = 32;
  localparam int PRESC_W_DEF = 8;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: state, counter, shadow period/mode, expire pulse
// TIMER_MULTI_STICKY_IRQ_EN adds a sticky interrupt flag with irq_clr_i.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             periodic_i,
  input  logic [WIDTH-1:0] period_i,
`ifdef TIMER_MULTI_STICKY_IRQ_EN
  input  logic             irq_clr_i,
`endif
  output logic             busy_o,
  output logic             expire_o,
  output logic             irq_o,
  output logic [WIDTH-1:0] count_o
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             periodic_q, periodic_d;
  logic             expire_q, expire_d;

  // Priority: stop, then start/retrigger, then tick-driven counting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start_i) begin
      state_d    = RUN;
      cnt_d      = '0;
      per_d      = period_i;
      periodic_d = periodic_i;
    end else if (state_q == RUN && tick_i) begin
      if (cnt_q == per_q) begin
        expire_d = 1'b1;
        cnt_d    = '0;
        if (periodic_q) per_d = period_i;
        else            state_d = IDLE;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
    end
  end

`ifdef TIMER_MULTI_STICKY_IRQ_EN
  logic flag_q, flag_d;

  // A new expiry overrides a clear arriving on the same edge.
  assign flag_d = expire_d | (flag_q & ~irq_clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flag_q <= 1'b0;
    else         flag_q <= flag_d;
  end

  assign irq_o = flag_q;
`else
  assign irq_o = expire_q;
`endif

  assign busy_o   = (state_q == RUN);
  assign expire_o = expire_q;
  assign count_o  = cnt_q;

endmodule

// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - multi-channel timer with shared prescaler
// TIMER_MULTI_STICKY_IRQ_EN selects sticky per-channel interrupts cleared by irq_clr_i.
module timer_multi
  import timer_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PRESC_W-1:0]      prescale_i,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       stop_i,
  input  logic [NUM_CH-1:0]       periodic_i,
  input  logic [NUM_CH*WIDTH-1:0] period_i,
`ifdef TIMER_MULTI_STICKY_IRQ_EN
  input  logic [NUM_CH-1:0]       irq_clr_i,
`endif
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       expire_o,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic                    irq_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               any_busy;
  logic               tick;
  logic [NUM_CH-1:0]  ch_irq;

  assign any_busy = |busy_o;
  assign tick     = any_busy && (presc_q == prescale_i);

  // Parked at 0 while idle so the first start always begins a fresh tick period.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if (!any_busy || tick) presc_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) presc_q <= '0;
    else         presc_q <= presc_d;
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick_i     (tick),
      .start_i    (start_i[n]),
      .stop_i     (stop_i[n]),
      .periodic_i (periodic_i[n]),
      .period_i   (period_i[n*WIDTH +: WIDTH]),
`ifdef TIMER_MULTI_STICKY_IRQ_EN
      .irq_clr_i  (irq_clr_i[n]),
`endif
      .busy_o     (busy_o[n]),
      .expire_o   (expire_o[n]),
      .irq_o      (ch_irq[n]),
      .count_o    (count_o[n*WIDTH +: WIDTH])
    );
  end

  assign irq_o = |ch_irq;

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - self-checking bench for timer_multi
module tb_timer_multi;

  localparam int NC = 4;
  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] presc;
  logic [NC-1:0] start, stop, periodic;
  logic [NC*W-1:0] period;
  logic [NC-1:0] busy, expire;
  logic [NC*W-1:0] count;
  logic          irq;
`ifdef TIMER_MULTI_STICKY_IRQ_EN
  logic [NC-1:0] irq_clr;
`endif

  always #5 clk = ~clk;

  timer_multi #(.NUM_CH(NC), .WIDTH(W), .PRESC_W(PW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .prescale_i (presc),
    .start_i    (start),
    .stop_i     (stop),
    .periodic_i (periodic),
    .period_i   (period),
`ifdef TIMER_MULTI_STICKY_IRQ_EN
    .irq_clr_i  (irq_clr),
`endif
    .busy_o     (busy),
    .expire_o   (expire),
    .count_o    (count),
    .irq_o      (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tick positions follow from cycles elapsed in the current busy epoch.
  bit m_run[NC];
  int m_cnt[NC];
  int m_per[NC];
  bit m_perd[NC];
  bit m_exp[NC];
  bit m_flag[NC];
  int m_epoch;
  bit m_any, m_tick;

  task automatic model_reset();
    for (int n = 0; n < NC; n++) begin
      m_run[n] = 0; m_cnt[n] = 0; m_per[n] = 0; m_perd[n] = 0; m_exp[n] = 0; m_flag[n] = 0;
    end
    m_epoch = 0;
  endtask

  task automatic model_step();
    bit clr;
    m_any = 0;
    for (int n = 0; n < NC; n++) m_any |= m_run[n];
    m_tick  = m_any && ((m_epoch % (int'(presc) + 1)) == int'(presc));
    m_epoch = m_any ? m_epoch + 1 : 0;
    for (int n = 0; n < NC; n++) begin
      m_exp[n] = 0;
      if (stop[n]) begin
        m_run[n] = 0; m_cnt[n] = 0;
      end else if (start[n]) begin
        m_run[n] = 1; m_cnt[n] = 0;
        m_per[n] = int'(period[n*W +: W]); m_perd[n] = periodic[n];
      end else if (m_run[n] && m_tick) begin
        if (m_cnt[n] == m_per[n]) begin
          m_exp[n] = 1; m_cnt[n] = 0;
          m_per[n] = int'(period[n*W +: W]);
          if (!m_perd[n]) m_run[n] = 0;
        end else begin
          m_cnt[n]++;
        end
      end
`ifdef TIMER_MULTI_STICKY_IRQ_EN
      clr = irq_clr[n];
`else
      clr = 0;
`endif
      m_flag[n] = m_exp[n] || (m_flag[n] && !clr);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic cyc(input logic [NC-1:0] s, input logic [NC-1:0] p);
    start = s;
    stop  = p;
    @(posedge clk);
    @(negedge clk);
    start = '0;
    stop  = '0;
  endtask

  task automatic check_model();
    bit any_irq;
    any_irq = 0;
    for (int n = 0; n < NC; n++) begin
      chk($sformatf("rnd busy[%0d]", n), busy[n], m_run[n]);
      chk($sformatf("rnd expire[%0d]", n), expire[n], m_exp[n]);
      chk($sformatf("rnd count[%0d]", n), count[n*W +: W], m_cnt[n]);
`ifdef TIMER_MULTI_STICKY_IRQ_EN
      any_irq |= m_flag[n];
`else
      any_irq |= m_exp[n];
`endif
    end
    chk("rnd irq", irq, any_irq);
  endtask

  typedef struct {
    bit st;
    bit sp;
    bit e_busy;
    bit e_exp;
    int e_cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0;
    presc = '0; start = '0; stop = '0; periodic = '0; period = '0;
`ifdef TIMER_MULTI_STICKY_IRQ_EN
    irq_clr = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset expire", expire, 0);
    chk("reset count", count, 0);
    chk("reset irq", irq, 0);
    rst_n = 1'b1;

    // Channel 0, period 3 one-shot, prescale 0: expiry, retrigger, stop vs expiry, start+stop.
    vecs = '{
      '{1,0,1,0,0}, '{0,0,1,0,1}, '{0,0,1,0,2}, '{0,0,1,0,3}, '{0,0,0,1,0}, '{0,0,0,0,0},
      '{1,0,1,0,0}, '{0,0,1,0,1}, '{0,0,1,0,2}, '{1,0,1,0,0}, '{0,0,1,0,1}, '{0,0,1,0,2},
      '{0,0,1,0,3}, '{0,1,0,0,0}, '{1,1,0,0,0}, '{1,0,1,0,0}, '{0,0,1,0,1}, '{0,0,1,0,2},
      '{0,0,1,0,3}, '{1,0,1,0,0}, '{0,0,1,0,1}, '{1,1,0,0,0}, '{0,0,0,0,0}
    };
    period[0 +: W] = 8'd3;
    for (int i = 0; i < vecs.size(); i++) begin
      cyc({3'b000, vecs[i].st}, {3'b000, vecs[i].sp});
      chk($sformatf("vec%0d busy0", i), busy[0], vecs[i].e_busy);
      chk($sformatf("vec%0d expire0", i), expire[0], vecs[i].e_exp);
      chk($sformatf("vec%0d count0", i), count[0 +: W], vecs[i].e_cnt);
`ifndef TIMER_MULTI_STICKY_IRQ_EN
      chk($sformatf("vec%0d irq", i), irq, vecs[i].e_exp);
`endif
    end

    // Channel 1, prescale 2, period 1 periodic: expiry every 6 cycles until stopped.
    presc = 4'd2; period[1*W +: W] = 8'd1; periodic[1] = 1'b1;
    cyc(4'b0010, 4'b0000);
    chk("p36 busy start", busy[1], 1);
    for (int i = 1; i <= 30; i++) begin
      cyc(4'b0000, 4'b0000);
      chk($sformatf("p36 expire i=%0d", i), expire[1], (i % 6) == 0);
    end
    cyc(4'b0000, 4'b0010);
    chk("p36 busy after stop", busy[1], 0);
    for (int i = 0; i < 14; i++) begin
      cyc(4'b0000, 4'b0000);
      chk("p36 expire after stop", expire[1], 0);
    end
    periodic[1] = 1'b0;

    // Channel 2, period 0 periodic: expiry on every cycle; stop overrides a pending expiry.
    presc = 4'd0; period[2*W +: W] = 8'd0; periodic[2] = 1'b1;
    cyc(4'b0100, 4'b0000);
    chk("p0 first expire", expire[2], 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(4'b0000, 4'b0000);
      chk("p0 expire", expire[2], 1);
      chk("p0 count", count[2*W +: W], 0);
`ifndef TIMER_MULTI_STICKY_IRQ_EN
      chk("p0 irq", irq, 1);
`endif
    end
    cyc(4'b0000, 4'b0100);
    chk("p0 stop no expire", expire[2], 0);
    chk("p0 stop busy", busy[2], 0);
    periodic[2] = 1'b0;

    // Channel 3, all-ones period: 256 ticks, counter never wraps before expiry.
    period[3*W +: W] = 8'hFF;
    cyc(4'b1000, 4'b0000);
    for (int i = 1; i <= 256; i++) begin
      cyc(4'b0000, 4'b0000);
      if (i == 255) begin
        chk("max count 255", count[3*W +: W], 255);
        chk("max no early expire", expire[3], 0);
      end
    end
    chk("max expire", expire[3], 1);
    chk("max busy drop", busy[3], 0);
    chk("max count clr", count[3*W +: W], 0);

    // Asynchronous reset mid-run at count 7.
    period[0 +: W] = 8'd20; periodic[0] = 1'b1;
    cyc(4'b0001, 4'b0000);
    for (int i = 1; i <= 7; i++) cyc(4'b0000, 4'b0000);
    chk("rst pre count", count[0 +: W], 7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async busy", busy, 0);
    chk("rst async expire", expire, 0);
    chk("rst async count", count, 0);
    chk("rst async irq", irq, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      cyc(4'b0000, 4'b0000);
      chk("rst post busy", busy, 0);
      chk("rst post expire", expire, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0001, 4'b0000);
    chk("rst first start", busy[0], 1);
    chk("rst first count", count[0 +: W], 0);
    cyc(4'b0000, 4'b0001);
    periodic[0] = 1'b0;

`ifdef TIMER_MULTI_STICKY_IRQ_EN
    period[0 +: W] = 8'd0;
    cyc(4'b0001, 4'b0000);
    cyc(4'b0000, 4'b0000);
    chk("sticky set", irq, 1);
    cyc(4'b0000, 4'b0000);
    chk("sticky hold", irq, 1);
    irq_clr = 4'b0001;
    cyc(4'b0000, 4'b0000);
    irq_clr = '0;
    chk("sticky clear", irq, 0);
    cyc(4'b0001, 4'b0000);
    irq_clr = 4'b0001;
    cyc(4'b0000, 4'b0000);
    irq_clr = '0;
    chk("sticky set wins", irq, 1);
    irq_clr = 4'b0001;
    cyc(4'b0000, 4'b0000);
    irq_clr = '0;
    chk("sticky clear 2", irq, 0);
`endif

    // Randomized traffic checked against the model, prescale fixed per block.
    for (int b = 0; b < 3; b++) begin
      presc = (b == 0) ? 4'd0 : (b == 1) ? 4'd1 : 4'd3;
      for (int c = 0; c < 400; c++) begin
        logic [NC-1:0] s, p;
        for (int n = 0; n < NC; n++) begin
          s[n] = ($urandom_range(0, 15) == 0);
          p[n] = ($urandom_range(0, 31) == 0);
          periodic[n] = $urandom_range(0, 1) == 1;
          period[n*W +: W] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                         : 8'($urandom_range(0, 6));
        end
`ifdef TIMER_MULTI_STICKY_IRQ_EN
        irq_clr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
`endif
        cyc(s, p);
        check_model();
      end
      cyc(4'b0000, 4'b1111);
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
